wire_pipe: RTL

- Parametrised successor to the plain pass-through wire feature block.
- Carries a WIDTH-bit word from input to output through DEPTH registered stages with valid/ready flow control.
- Each stage collapses bubbles, so backpressure stalls only as far upstream as needed.
- Used as a routing/timing feature design for place-and-route tests; also exports occupancy for bench checking.

---
 rtl/wire_pipe.sv | 71 +++++++
 1 files changed

// File: rtl/wire_pipe.sv
// wire_pipe: DEPTH-stage valid/ready register pipeline with bubble collapse
// and a registered occupancy count.
module wire_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             o_ready,
    output logic [CW-1:0]    count
);
    logic [DEPTH-1:0] v_q, v_d, r;
    logic [DEPTH:0]   vc;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [WIDTH-1:0] d_d [DEPTH];
    logic [WIDTH-1:0] dc  [DEPTH+1];
    logic [CW-1:0]    count_q, count_d;
    logic             acc;

    // Stage k sees its predecessor at index k of the chain; index 0 is the input.
    assign vc = {v_q, i_valid};

    // A stage is ready if it, or any stage downstream of it, has room.
    always_comb begin
        acc = o_ready;
        r   = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            acc  = acc | ~v_q[k];
            r[k] = acc;
        end
    end

    always_comb begin
        dc[0] = i_data;
        for (int k = 0; k < DEPTH; k++) dc[k+1] = d_q[k];
    end

    always_comb begin
        v_d     = v_q;
        d_d     = d_q;
        count_d = '0;
        for (int k = 0; k < DEPTH; k++) begin
            v_d[k]  = r[k] ? vc[k] : v_q[k];
            d_d[k]  = (r[k] && vc[k]) ? dc[k] : d_q[k];
            count_d = count_d + CW'(v_d[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q     <= '0;
            d_q     <= '{default: '0};
            count_q <= '0;
        end else begin
            v_q     <= v_d;
            d_q     <= d_d;
            count_q <= count_d;
        end
    end

    assign i_ready = rst_n & r[0];
    assign o_valid = v_q[DEPTH-1];
    assign o_data  = d_q[DEPTH-1];
    assign count   = count_q;
endmodule
